// File: rtl/apb_ucpd_tx_sched.sv
// Purpose: UCPD transmit scheduler that arbitrates message and hard-reset requests, sequences the TX FSM and enforces the interframe gap.
// Latency: a request sampled at edge N moves the state to MSG/HRST at edge N+1. Completion pulses are registered, one cycle after the done edge.
// Backpressure: none. A request is held as a pending flag until the scheduler returns to IDLE. A repeat request while that flag is set or its state is active is dropped.
// Optional feature: define UCPD_TX_TIMEOUT_EN to build the MSG/HRST watchdog that drives tx_err.
module apb_ucpd_tx_sched #(
  parameter int TO_W  = 16,
  parameter int GAP_W = 8
) (
  input  logic             ic_clk,
  input  logic             ic_rst_n,
  input  logic             ucpden,
  input  logic             txsend_req,
  input  logic             txhrst_req,
  input  logic             rx_busy,
  input  logic             tx_msg_done,
  input  logic             tx_hrst_done,
  input  logic             tx_und,
  input  logic [GAP_W-1:0] cfg_ifrgap,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             transmit_en,
  output logic             tx_hrst,
  output logic             sched_busy,
  output logic             txmsgsent,
  output logic             txmsgdisc,
  output logic             txmsgabt,
  output logic             hrstsent,
  output logic             hrstdisc,
  output logic             tx_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    HRST = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             msg_pend_q, msg_pend_d;
  logic             hrst_pend_q, hrst_pend_d;
  logic             und_seen_q, und_seen_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             txmsgsent_q, txmsgsent_d;
  logic             txmsgdisc_q, txmsgdisc_d;
  logic             txmsgabt_q, txmsgabt_d;
  logic             hrstsent_q, hrstsent_d;
  logic             hrstdisc_q, hrstdisc_d;

`ifdef UCPD_TX_TIMEOUT_EN
  logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             tx_err_q, tx_err_d;
  logic             wd_hit;

  // The watchdog counter holds (cycles spent in the state - 1), so a threshold of T fires on the T-th cycle.
  assign wd_hit = (cfg_timeout != '0) && (wd_cnt_q == (cfg_timeout - TO_W'(1)));
  assign tx_err = tx_err_q;

  // The watchdog restarts on every entry into MSG/HRST and saturates instead of wrapping.
  always_comb begin
    wd_cnt_d = '0;
    if (ucpden && (state_d == state_q) && ((state_q == MSG) || (state_q == HRST))) begin
      wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + TO_W'(1);
    end
  end
`else
  logic             unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
  assign tx_err = 1'b0;
`endif

  assign transmit_en = (state_q == MSG);
  assign tx_hrst     = (state_q == HRST) || ((state_q == MSG) && hrst_pend_q);
  assign sched_busy  = (state_q != IDLE) || msg_pend_q || hrst_pend_q;
  assign txmsgsent   = txmsgsent_q;
  assign txmsgdisc   = txmsgdisc_q;
  assign txmsgabt    = txmsgabt_q;
  assign hrstsent    = hrstsent_q;
  assign hrstdisc    = hrstdisc_q;

  // This block captures requests, runs the scheduler state machine and computes the completion pulses.
  always_comb begin
    state_d     = state_q;
    msg_pend_d  = msg_pend_q;
    hrst_pend_d = hrst_pend_q;
    und_seen_d  = und_seen_q;
    gap_cnt_d   = gap_cnt_q;
    txmsgsent_d = 1'b0;
    txmsgdisc_d = 1'b0;
    txmsgabt_d  = 1'b0;
    hrstsent_d  = 1'b0;
    hrstdisc_d  = 1'b0;
`ifdef UCPD_TX_TIMEOUT_EN
    tx_err_d    = 1'b0;
`endif
    // A request is captured unless its own state is already running. A flag that is already set stays set.
    if (txsend_req && (state_q != MSG))  msg_pend_d  = 1'b1;
    if (txhrst_req && (state_q != HRST)) hrst_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (hrst_pend_q) begin
          hrst_pend_d = 1'b0;
          if (rx_busy) hrstdisc_d = 1'b1;
          else         state_d    = HRST;
        end else if (msg_pend_q) begin
          msg_pend_d = 1'b0;
          if (rx_busy) txmsgdisc_d = 1'b1;
          else         state_d     = MSG;
        end
      end
      MSG: begin
        if (tx_und) und_seen_d = 1'b1;
        if (tx_msg_done) begin
          und_seen_d = 1'b0;
          if (hrst_pend_q) begin
            txmsgabt_d  = 1'b1;
            hrst_pend_d = 1'b0;
            state_d     = HRST;
          end else begin
            // An underrun reported in the same cycle as done still aborts the message.
            if (und_seen_q || tx_und) txmsgabt_d  = 1'b1;
            else                      txmsgsent_d = 1'b1;
            state_d   = GAP;
            gap_cnt_d = cfg_ifrgap;
          end
        end
`ifdef UCPD_TX_TIMEOUT_EN
        else if (wd_hit) begin
          tx_err_d   = 1'b1;
          und_seen_d = 1'b0;
          state_d    = GAP;
          gap_cnt_d  = cfg_ifrgap;
        end
`endif
      end
      HRST: begin
        if (tx_hrst_done) begin
          hrstsent_d = 1'b1;
          state_d    = GAP;
          gap_cnt_d  = cfg_ifrgap;
        end
`ifdef UCPD_TX_TIMEOUT_EN
        else if (wd_hit) begin
          tx_err_d  = 1'b1;
          state_d   = GAP;
          gap_cnt_d = cfg_ifrgap;
        end
`endif
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d   = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // When the peripheral is disabled, the scheduler is flushed synchronously and all pulses are suppressed.
    if (!ucpden) begin
      state_d     = IDLE;
      msg_pend_d  = 1'b0;
      hrst_pend_d = 1'b0;
      und_seen_d  = 1'b0;
      gap_cnt_d   = '0;
      txmsgsent_d = 1'b0;
      txmsgdisc_d = 1'b0;
      txmsgabt_d  = 1'b0;
      hrstsent_d  = 1'b0;
      hrstdisc_d  = 1'b0;
`ifdef UCPD_TX_TIMEOUT_EN
      tx_err_d    = 1'b0;
`endif
    end
  end

  // This block holds the state, the pending flags, the counters and the registered pulses, all cleared by async reset.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_q     <= IDLE;
      msg_pend_q  <= 1'b0;
      hrst_pend_q <= 1'b0;
      und_seen_q  <= 1'b0;
      gap_cnt_q   <= '0;
      txmsgsent_q <= 1'b0;
      txmsgdisc_q <= 1'b0;
      txmsgabt_q  <= 1'b0;
      hrstsent_q  <= 1'b0;
      hrstdisc_q  <= 1'b0;
`ifdef UCPD_TX_TIMEOUT_EN
      wd_cnt_q    <= '0;
      tx_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      msg_pend_q  <= msg_pend_d;
      hrst_pend_q <= hrst_pend_d;
      und_seen_q  <= und_seen_d;
      gap_cnt_q   <= gap_cnt_d;
      txmsgsent_q <= txmsgsent_d;
      txmsgdisc_q <= txmsgdisc_d;
      txmsgabt_q  <= txmsgabt_d;
      hrstsent_q  <= hrstsent_d;
      hrstdisc_q  <= hrstdisc_d;
`ifdef UCPD_TX_TIMEOUT_EN
      wd_cnt_q    <= wd_cnt_d;
      tx_err_q    <= tx_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Directed bench for apb_ucpd_tx_sched: reset, send/gap timing, priority, discard, abort, disable, watchdog.
// Inputs change 1 time unit after the rising edge, and outputs are checked at that same point.
module tb_apb_ucpd_tx_sched;
  logic        ic_clk = 1'b0;
  logic        ic_rst_n;
  logic        ucpden, txsend_req, txhrst_req, rx_busy;
  logic        tx_msg_done, tx_hrst_done, tx_und;
  logic [7:0]  cfg_ifrgap;
  logic [15:0] cfg_timeout;
  logic        transmit_en, tx_hrst, sched_busy;
  logic        txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc, tx_err;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  apb_ucpd_tx_sched #(.TO_W(16), .GAP_W(8)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden),
    .txsend_req(txsend_req), .txhrst_req(txhrst_req), .rx_busy(rx_busy),
    .tx_msg_done(tx_msg_done), .tx_hrst_done(tx_hrst_done), .tx_und(tx_und),
    .cfg_ifrgap(cfg_ifrgap), .cfg_timeout(cfg_timeout),
    .transmit_en(transmit_en), .tx_hrst(tx_hrst), .sched_busy(sched_busy),
    .txmsgsent(txmsgsent), .txmsgdisc(txmsgdisc), .txmsgabt(txmsgabt),
    .hrstsent(hrstsent), .hrstdisc(hrstdisc), .tx_err(tx_err)
  );

  always #5 ic_clk = ~ic_clk;

  task automatic tick();
    @(posedge ic_clk);
    #1;
  endtask

  // Enter MSG: the request is sampled at edge 0, and the state is MSG after edge 1.
  task automatic start_msg();
    txsend_req = 1'b1; tick(); txsend_req = 0; tick();
  endtask

  task automatic test_reset();
    ic_rst_n = 1'b0; ucpden = 1'b1; txsend_req = 0; txhrst_req = 0; rx_busy = 0;
    tx_msg_done = 0; tx_hrst_done = 0; tx_und = 0; cfg_ifrgap = 8'd4; cfg_timeout = 16'd0;
    tick(); tick();
    total_cnt++; if ({transmit_en, tx_hrst, sched_busy} !== 3'b000) $display("FAIL reset_levels got %b exp 000", {transmit_en, tx_hrst, sched_busy}); else pass_cnt++;
    total_cnt++; if ({txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc, tx_err} !== 6'b0) $display("FAIL reset_pulses got %b exp 000000", {txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc, tx_err}); else pass_cnt++;
    ic_rst_n = 1'b1; tick();
  endtask

  task automatic test_basic_send();
    cfg_ifrgap = 8'd4;
    txsend_req = 1'b1; tick(); txsend_req = 0;
    total_cnt++; if ({transmit_en, sched_busy} !== 2'b01) $display("FAIL send_pending got %b exp 01", {transmit_en, sched_busy}); else pass_cnt++;
    tick();
    total_cnt++; if ({transmit_en, tx_hrst} !== 2'b10) $display("FAIL send_msg_state got %b exp 10", {transmit_en, tx_hrst}); else pass_cnt++;
    tick(); tick();
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgsent, txmsgabt, transmit_en} !== 3'b100) $display("FAIL send_done got %b exp 100", {txmsgsent, txmsgabt, transmit_en}); else pass_cnt++;
    tick();
    total_cnt++; if (txmsgsent !== 1'b0) $display("FAIL send_pulse_width got %b exp 0", txmsgsent); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (sched_busy !== 1'b1) $display("FAIL gap4_still_busy got %b exp 1", sched_busy); else pass_cnt++;
    tick();
    total_cnt++; if (sched_busy !== 1'b0) $display("FAIL gap4_idle got %b exp 0", sched_busy); else pass_cnt++;
  endtask

  task automatic test_gap_zero();
    cfg_ifrgap = 8'd0;
    start_msg();
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({sched_busy, transmit_en} !== 2'b10) $display("FAIL gap0_one_cycle got %b exp 10", {sched_busy, transmit_en}); else pass_cnt++;
    tick();
    total_cnt++; if (sched_busy !== 1'b0) $display("FAIL gap0_idle got %b exp 0", sched_busy); else pass_cnt++;
  endtask

  task automatic test_both_requests();
    cfg_ifrgap = 8'd2;
    txsend_req = 1'b1; txhrst_req = 1'b1; tick(); txsend_req = 0; txhrst_req = 0;
    tick();
    total_cnt++; if ({tx_hrst, transmit_en} !== 2'b10) $display("FAIL both_hrst_first got %b exp 10", {tx_hrst, transmit_en}); else pass_cnt++;
    tx_hrst_done = 1'b1; tick(); tx_hrst_done = 0;
    total_cnt++; if ({hrstsent, tx_hrst, sched_busy} !== 3'b101) $display("FAIL both_hrstsent got %b exp 101", {hrstsent, tx_hrst, sched_busy}); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if ({transmit_en, txmsgdisc, sched_busy} !== 3'b001) $display("FAIL both_msg_waiting got %b exp 001", {transmit_en, txmsgdisc, sched_busy}); else pass_cnt++;
    tick();
    total_cnt++; if (transmit_en !== 1'b1) $display("FAIL both_msg_served got %b exp 1", transmit_en); else pass_cnt++;
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if (txmsgsent !== 1'b1) $display("FAIL both_msgsent got %b exp 1", txmsgsent); else pass_cnt++;
    repeat (4) tick();
  endtask

  task automatic test_discard();
    rx_busy = 1'b1;
    txsend_req = 1'b1; tick(); txsend_req = 0; tick();
    total_cnt++; if ({txmsgdisc, transmit_en} !== 2'b10) $display("FAIL disc_msg got %b exp 10", {txmsgdisc, transmit_en}); else pass_cnt++;
    tick();
    total_cnt++; if ({txmsgdisc, transmit_en, sched_busy} !== 3'b000) $display("FAIL disc_msg_after got %b exp 000", {txmsgdisc, transmit_en, sched_busy}); else pass_cnt++;
    txhrst_req = 1'b1; tick(); txhrst_req = 0; tick();
    total_cnt++; if ({hrstdisc, tx_hrst} !== 2'b10) $display("FAIL disc_hrst got %b exp 10", {hrstdisc, tx_hrst}); else pass_cnt++;
    tick();
    total_cnt++; if ({hrstdisc, sched_busy} !== 2'b00) $display("FAIL disc_hrst_after got %b exp 00", {hrstdisc, sched_busy}); else pass_cnt++;
    rx_busy = 1'b0;
  endtask

  task automatic test_hrst_during_msg();
    cfg_ifrgap = 8'd1;
    start_msg();
    txhrst_req = 1'b1; tick(); txhrst_req = 0;
    total_cnt++; if ({tx_hrst, transmit_en} !== 2'b11) $display("FAIL abort_hrst_overlay got %b exp 11", {tx_hrst, transmit_en}); else pass_cnt++;
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgabt, txmsgsent, tx_hrst, transmit_en} !== 4'b1010) $display("FAIL abort_to_hrst got %b exp 1010", {txmsgabt, txmsgsent, tx_hrst, transmit_en}); else pass_cnt++;
    tick();
    tx_hrst_done = 1'b1; tick(); tx_hrst_done = 0;
    total_cnt++; if ({hrstsent, tx_hrst} !== 2'b10) $display("FAIL abort_hrstsent got %b exp 10", {hrstsent, tx_hrst}); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (sched_busy !== 1'b0) $display("FAIL abort_idle got %b exp 0", sched_busy); else pass_cnt++;
  endtask

  task automatic test_underrun();
    cfg_ifrgap = 8'd1;
    start_msg();
    tx_und = 1'b1; txsend_req = 1'b1; tick(); tx_und = 0; txsend_req = 0;
    tick();
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgabt, txmsgsent} !== 2'b10) $display("FAIL und_abort got %b exp 10", {txmsgabt, txmsgsent}); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if ({sched_busy, transmit_en} !== 2'b00) $display("FAIL und_req_ignored got %b exp 00", {sched_busy, transmit_en}); else pass_cnt++;
  endtask

  task automatic test_disable();
    cfg_ifrgap = 8'd1;
    start_msg();
    ucpden = 1'b0; tx_und = 1'b1; tx_msg_done = 1'b1; tick(); tx_und = 0; tx_msg_done = 0;
    total_cnt++; if ({transmit_en, sched_busy} !== 2'b00) $display("FAIL dis_idle got %b exp 00", {transmit_en, sched_busy}); else pass_cnt++;
    total_cnt++; if ({txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc, tx_err} !== 6'b0) $display("FAIL dis_no_pulse got %b exp 000000", {txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc, tx_err}); else pass_cnt++;
    tick(); ucpden = 1'b1;
    start_msg();
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgsent, txmsgabt} !== 2'b10) $display("FAIL dis_und_cleared got %b exp 10", {txmsgsent, txmsgabt}); else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    start_msg();
    #2 ic_rst_n = 1'b0; #1;
    total_cnt++; if ({transmit_en, tx_hrst, sched_busy} !== 3'b000) $display("FAIL areset_drop got %b exp 000", {transmit_en, tx_hrst, sched_busy}); else pass_cnt++;
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgsent, txmsgabt} !== 2'b00) $display("FAIL areset_no_pulse got %b exp 00", {txmsgsent, txmsgabt}); else pass_cnt++;
    ic_rst_n = 1'b1; tick();
  endtask

  task automatic test_timeout();
    cfg_ifrgap = 8'd0; cfg_timeout = 16'd10;
`ifdef UCPD_TX_TIMEOUT_EN
    start_msg();
    repeat (9) tick();
    total_cnt++; if ({transmit_en, tx_err} !== 2'b10) $display("FAIL wd_before got %b exp 10", {transmit_en, tx_err}); else pass_cnt++;
    tick();
    total_cnt++; if ({tx_err, transmit_en, txmsgsent, txmsgabt} !== 4'b1000) $display("FAIL wd_fire got %b exp 1000", {tx_err, transmit_en, txmsgsent, txmsgabt}); else pass_cnt++;
    tick();
    total_cnt++; if (tx_err !== 1'b0) $display("FAIL wd_pulse_width got %b exp 0", tx_err); else pass_cnt++;
    tick();
    start_msg();
    repeat (9) tick();
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgsent, tx_err} !== 2'b10) $display("FAIL wd_done_wins got %b exp 10", {txmsgsent, tx_err}); else pass_cnt++;
    tick(); tick();
`else
    start_msg();
    repeat (20) tick();
    total_cnt++; if ({transmit_en, tx_err} !== 2'b10) $display("FAIL nowd_stays got %b exp 10", {transmit_en, tx_err}); else pass_cnt++;
    tx_msg_done = 1'b1; tick(); tx_msg_done = 0;
    total_cnt++; if ({txmsgsent, tx_err} !== 2'b10) $display("FAIL nowd_done got %b exp 10", {txmsgsent, tx_err}); else pass_cnt++;
    tick(); tick();
`endif
    cfg_timeout = 16'd0;
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_gap_zero();
    test_both_requests();
    test_discard();
    test_hrst_during_msg();
    test_underrun();
    test_disable();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/apb_ucpd_tx_sched.md
APB_UCPD_TX_SCHED -- requirements
Module: apb_ucpd_tx_sched

Interface
REQ-001 SHALL have parameter TO_W, default 16, watchdog counter/threshold width.
REQ-002 SHALL have parameter GAP_W, default 8, interframe-gap counter width.
REQ-003 SHALL have port ic_clk  input  1  single block clock (HSI16 domain).
REQ-004 SHALL have port ic_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports ucpden  input  1  peripheral enable; txsend_req  input  1  SW message-send pulse; txhrst_req  input  1  SW hard-reset pulse.
REQ-006 SHALL have ports rx_busy  input  1  receiver in SOP/DATA; tx_msg_done  input  1  TX FSM wait-complete pulse; tx_hrst_done  input  1  TX FSM hard-reset SOP complete pulse; tx_und  input  1  TX underrun level.
REQ-007 SHALL have ports cfg_ifrgap  input  GAP_W  gap length in ic_clk cycles; cfg_timeout  input  TO_W  watchdog threshold, 0 = disabled.
REQ-008 SHALL have ports transmit_en  output  1; tx_hrst  output  1; sched_busy  output  1 (state != IDLE or any pending flag).
REQ-009 SHALL have one-cycle pulse outputs txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc, tx_err, each 1 bit.

Function
REQ-010 SHALL implement states IDLE, MSG, HRST, GAP in a 2-bit registered state.
REQ-011 SHALL set msg_pend on the edge sampling txsend_req and hrst_pend on the edge sampling txhrst_req; a request arriving while its flag is set or its state is active SHALL be ignored.
REQ-012 IDLE, ucpden=1: hrst_pend has priority; if rx_busy -> hrstdisc pulse, clear hrst_pend, stay IDLE; else -> HRST, clear hrst_pend.
REQ-013 IDLE, no hrst_pend, msg_pend: if rx_busy -> txmsgdisc pulse, clear msg_pend; else -> MSG, clear msg_pend.
REQ-014 Latency: request sampled at edge N -> state MSG/HRST after edge N+1; transmit_en/tx_hrst decoded from state, so asserted in cycle after edge N+1.
REQ-015 transmit_en SHALL equal (state==MSG); tx_hrst SHALL equal (state==HRST) or (state==MSG and hrst_pend).
REQ-016 MSG SHALL record und_seen (sticky) whenever tx_und=1; cleared on leaving MSG.
REQ-017 MSG on tx_msg_done: hrst_pend=1 -> txmsgabt, go HRST, clear hrst_pend; else und_seen -> txmsgabt, go GAP; else txmsgsent, go GAP.
REQ-018 HRST on tx_hrst_done -> hrstsent pulse, go GAP.
REQ-019 GAP SHALL load gap counter with cfg_ifrgap on entry, decrement each cycle, exit to IDLE when counter==0; cfg_ifrgap=0 -> exactly one cycle in GAP; counter SHALL not wrap.
REQ-020 Requests during GAP SHALL be held pending, served on return to IDLE.
REQ-021 ucpden=0 SHALL synchronously force IDLE, clear both pend flags, und_seen and counters, and suppress all pulses.
REQ-022 All pulse outputs SHALL be registered, high exactly one cycle.

Reset
REQ-023 On ic_rst_n=0: state IDLE, pend flags 0, counters 0, transmit_en=0, tx_hrst=0, sched_busy=0, all pulses 0.
REQ-024 Reset mid-MSG/HRST SHALL drop transmit_en/tx_hrst immediately (asynchronously) with no completion pulse.

Configuration
REQ-025 With UCPD_TX_TIMEOUT_EN defined: watchdog counts cycles in MSG/HRST, reset on entry; on reaching cfg_timeout (nonzero) -> tx_err pulse, go GAP, no sent/abt pulse; done and timeout in same cycle -> done wins.
REQ-026 Without UCPD_TX_TIMEOUT_EN: no watchdog logic, tx_err tied 0, cfg_timeout unused.

Verification
REQ-027 txsend_req at edge 0, rx_busy=0, cfg_ifrgap=4 -> transmit_en high after edge 1; tx_msg_done -> txmsgsent 1 cycle; IDLE 5 cycles later.
REQ-028 txsend_req and txhrst_req same cycle -> HRST first, hrstsent, GAP, then MSG served; msg never discarded.
REQ-029 txsend_req with rx_busy=1 -> txmsgdisc 1 cycle, transmit_en never asserted, sched_busy 0 after.
REQ-030 txhrst_req during MSG -> tx_hrst=1 with transmit_en=1; tx_msg_done -> txmsgabt then HRST; tx_hrst_done -> hrstsent.
REQ-031 UCPD_TX_TIMEOUT_EN, cfg_timeout=10, no done -> tx_err after 10 cycles in MSG, transmit_en low next cycle.
REQ-032 ucpden deasserted in MSG with tx_und pulse -> IDLE next cycle, no pulses; re-enable + txsend -> txmsgsent (und_seen cleared).
